// File: rtl/spi_slv_pkg.sv
// -----------------------------------------------------------------------------
// spi_slv_pkg
// Shared types and constants for the SPI slave endpoint.
//   spi_slv_state_e : endpoint FSM states
//   spi_slv_cfg_t   : per-transfer configuration captured at select fall
//   SPI_SLV_MIN_SYNC: smallest synchroniser depth the endpoint will build
// -----------------------------------------------------------------------------
package spi_slv_pkg;

  localparam int SPI_SLV_MIN_SYNC = 2;

  // Wide enough for any character-length field up to a 256-bit data width.
  localparam int SPI_SLV_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } spi_slv_state_e;

  typedef struct packed {
    logic                     cpol;
    logic                     cpha;
    logic                     lsb;
    logic [SPI_SLV_LEN_W-1:0] char_len;
  } spi_slv_cfg_t;

endpackage

// File: rtl/spi_slv_sync.sv
// -----------------------------------------------------------------------------
// spi_slv_sync
// N-stage synchroniser for one asynchronous pin, followed by an edge detector
// on the synchronised value.
//   clk, rst  : system clock, asynchronous active-low reset
//   d         : asynchronous pad input
//   q         : synchronised level
//   rise/fall : one-cycle strobes on a synchronised 0->1 / 1->0 transition
// RESET_VAL sets the level the chain (and edge history) holds in reset, so
// no spurious edge is reported when the pin sits at that level.
// -----------------------------------------------------------------------------
module spi_slv_sync
  import spi_slv_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // Depths below the metastability minimum are silently raised to it.
  localparam int N = (STAGES < SPI_SLV_MIN_SYNC) ? SPI_SLV_MIN_SYNC : STAGES;

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
    prev_d = sync_q[N-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {N{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[N-1];
  assign rise = sync_q[N-1] & ~prev_q;
  assign fall = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/spi_slave_endpoint.sv
// -----------------------------------------------------------------------------
// spi_slave_endpoint
// Oversampling SPI slave living in the system clk domain.
//   clk, rst             : system clock, asynchronous active-low reset
//   ss_pad_i[SS_NB]      : active-low selects; cfg_ss_idx picks ours
//   sclk_pad_i, mosi_pad_i, miso_pad_o, miso_oe_o : SPI pins
//   cfg_ss_idx/cpol/cpha/lsb/char_len : mode, captured at each select fall
//   tx_data/tx_valid/tx_ready : single-entry transmit buffer write port
//   rx_data/rx_valid     : received character (right-aligned) + strobe
//   tx_underrun, abort   : one-cycle event strobes
// Characters repeat back-to-back while the select is held low; each one
// reloads the shift register from the TX buffer (zeros if empty).
// -----------------------------------------------------------------------------
module spi_slave_endpoint
  import spi_slv_pkg::*;
#(
  parameter int SS_NB       = 8,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SS_NB-1:0]         ss_pad_i,
  input  logic                     sclk_pad_i,
  input  logic                     mosi_pad_i,
  output logic                     miso_pad_o,
  output logic                     miso_oe_o,
  input  logic [$clog2(SS_NB)-1:0] cfg_ss_idx,
  input  logic                     cfg_cpol,
  input  logic                     cfg_cpha,
  input  logic                     cfg_lsb,
  input  logic [$clog2(DW)-1:0]    cfg_char_len,
  input  logic [DW-1:0]            tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [DW-1:0]            rx_data,
  output logic                     rx_valid,
  output logic                     tx_underrun,
  output logic                     abort
);

  localparam int SEL_W = $clog2(SS_NB);
  localparam int IDX_W = $clog2(DW);
  localparam int CNT_W = $clog2(DW + 1);

  spi_slv_state_e state_q, state_d;
  spi_slv_cfg_t   cfg_q, cfg_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    tx_shift_q, tx_shift_d;
  logic [DW-1:0]    rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    buf_q, buf_d;
  logic             full_q, full_d;
  logic [DW-1:0]    rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic             abort_q, abort_d;

  logic ss_raw, ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  // Until a transfer starts we watch the live index; once committed the
  // latched one is used so a config change cannot drop the select mid-transfer.
  assign ss_raw = ss_pad_i[(state_q == IDLE) ? cfg_ss_idx : sel_q];

  spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss_raw), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk_pad_i), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi_pad_i), .q(mosi_s),
    .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  logic [CNT_W-1:0] len;
  logic [IDX_W-1:0] len_m1;
  logic             lead_ev, trail_ev, sample_ev, shift_ev, last_bit;
  logic [DW-1:0]    rx_next, miso_src;
  logic             unused_ss_level, unused_sclk_level;

  assign unused_ss_level   = ss_s;
  assign unused_sclk_level = sclk_s;

  // Decode the latched mode into edge roles and the effective length.
  always_comb begin
    len       = (cfg_q.char_len == '0) ? CNT_W'(DW) : CNT_W'(cfg_q.char_len);
    len_m1    = IDX_W'(len - 1'b1);
    lead_ev   = cfg_q.cpol ? sclk_fall : sclk_rise;
    trail_ev  = cfg_q.cpol ? sclk_rise : sclk_fall;
    sample_ev = cfg_q.cpha ? trail_ev : lead_ev;
    shift_ev  = cfg_q.cpha ? lead_ev : trail_ev;
    last_bit  = ((cnt_q + 1'b1) == len);
    // MSB-first fills from bit 0 upward; LSB-first drops each bit in at
    // len-1 and walks it down, so both end right-aligned with zero upper bits.
    if (cfg_q.lsb) rx_next = (rx_shift_q >> 1) | (DW'(mosi_s) << len_m1);
    else           rx_next = {rx_shift_q[DW-2:0], mosi_s};
  end

  // Main FSM, bit counter, shift registers and TX buffer bookkeeping.
  // A shift edge is ignored while the counter is 0: that is either before the
  // first bit (CPHA=1 presents bit 0 without shifting) or right after a reload
  // (CPHA=0 trailing edge that follows the final sample).
  always_comb begin
    logic drain;
    state_d    = state_q;
    cfg_d      = cfg_q;
    sel_d      = sel_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    full_d     = full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    drain      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          cfg_d.cpol     = cfg_cpol;
          cfg_d.cpha     = cfg_cpha;
          cfg_d.lsb      = cfg_lsb;
          cfg_d.char_len = SPI_SLV_LEN_W'(cfg_char_len);
          sel_d          = cfg_ss_idx;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        drain      = 1'b1;
        tx_shift_d = full_q ? buf_q : '0;
        underrun_d = !full_q;
        cnt_d      = '0;
        rx_shift_d = '0;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        if (sample_ev) begin
          if (last_bit) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            rx_shift_d = '0;
            // No point reloading when the select is closing this cycle.
            if (!ss_rise) begin
              drain      = 1'b1;
              tx_shift_d = full_q ? buf_q : '0;
              underrun_d = !full_q;
            end
          end else begin
            rx_shift_d = rx_next;
            cnt_d      = cnt_q + 1'b1;
          end
        end else if (shift_ev && (cnt_q != '0)) begin
          tx_shift_d = cfg_q.lsb ? (tx_shift_q >> 1) : (tx_shift_q << 1);
        end
        if (ss_rise) begin
          state_d = IDLE;
          abort_d = (cnt_q != '0) && !(sample_ev && last_bit);
        end
      end
      default: state_d = IDLE;
    endcase

    // A write can only land while empty, so it never collides with a drain
    // of real data; an empty-buffer reload plus a write leaves the new word.
    if (drain) full_d = 1'b0;
    if (tx_valid && !full_q) begin
      full_d = 1'b1;
      buf_d  = tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      sel_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      sel_q      <= sel_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  // During LOAD the shift register is still being filled, so the first bit
  // is taken straight from the buffer to have it on the pin immediately.
  always_comb begin
    miso_oe_o  = (state_q == LOAD) || (state_q == ACTIVE);
    miso_src   = (state_q == LOAD) ? (full_q ? buf_q : '0) : tx_shift_q;
    miso_pad_o = miso_oe_o & (cfg_q.lsb ? miso_src[0] : miso_src[len_m1]);
  end

  assign tx_ready    = !full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_endpoint
// Acts as the SPI master: drives select/SCLK/MOSI per mode, collects MISO
// bits, and compares against words derived from the TX/MOSI data.
// -----------------------------------------------------------------------------
module tb_spi_slave_endpoint;

  localparam int SS_NB = 8;
  localparam int DW    = 32;
  localparam int HALF  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [SS_NB-1:0] ss_pad_i;
  logic             sclk_pad_i, mosi_pad_i;
  logic             miso_pad_o, miso_oe_o;
  logic [2:0]       cfg_ss_idx;
  logic             cfg_cpol, cfg_cpha, cfg_lsb;
  logic [4:0]       cfg_char_len;
  logic [DW-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [DW-1:0]    rx_data;
  logic             rx_valid, tx_underrun, abort;

  int compared = 0, mismatched = 0;
  int rxCount = 0, underrunCount = 0, abortCount = 0, oeCount = 0;
  logic [DW-1:0] rxQ[$];

  int selIdx = 0;
  bit mCpol, mCpha, mLsb;

  spi_slave_endpoint #(.SS_NB(SS_NB), .DW(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ss_pad_i(ss_pad_i), .sclk_pad_i(sclk_pad_i),
    .mosi_pad_i(mosi_pad_i), .miso_pad_o(miso_pad_o), .miso_oe_o(miso_oe_o),
    .cfg_ss_idx(cfg_ss_idx), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb(cfg_lsb), .cfg_char_len(cfg_char_len), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .abort(abort)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxCount++;
      rxQ.push_back(rx_data);
    end
    if (tx_underrun === 1'b1) underrunCount++;
    if (abort === 1'b1) abortCount++;
    if (miso_oe_o === 1'b1) oeCount++;
  end

  function automatic logic [DW-1:0] maskLen(input logic [DW-1:0] w, input int len);
    logic [DW-1:0] m;
    m = (len >= DW) ? '1 : ((DW'(1) << len) - 1);
    return w & m;
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic failTimeout(input string tag);
    compared++;
    mismatched++;
    $error("[TB] FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic writeTx(input logic [DW-1:0] d);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 400) begin
      waitClk(1);
      n++;
    end
    if (tx_ready !== 1'b1) failTimeout("tx_ready_wait");
    tx_data  = d;
    tx_valid = 1'b1;
    waitClk(1);
    tx_valid = 1'b0;
  endtask

  task automatic setMode(input int mode, input bit lsb, input int len);
    mCpol        = mode[1];
    mCpha        = mode[0];
    mLsb         = lsb;
    cfg_cpol     = mCpol;
    cfg_cpha     = mCpha;
    cfg_lsb      = lsb;
    cfg_char_len = 5'(len % DW);
  endtask

  task automatic beginSelect();
    sclk_pad_i = mCpol;
    mosi_pad_i = 1'b0;
    waitClk(10);
    ss_pad_i[selIdx] = 1'b0;
    waitClk(8);
  endtask

  task automatic endSelect();
    waitClk(HALF);
    ss_pad_i = '1;
    waitClk(12);
  endtask

  // Master side of one character (or its first nbits bits).
  task automatic applyStimulus(input logic [DW-1:0] mosiWord, input int len, input int nbits,
                               output logic [DW-1:0] misoWord);
    int idx;
    misoWord = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = mLsb ? i : len - 1 - i;
      if (!mCpha) begin
        mosi_pad_i = mosiWord[idx];
        waitClk(HALF);
        misoWord[idx] = miso_pad_o;
        sclk_pad_i = ~mCpol;
        waitClk(HALF);
        sclk_pad_i = mCpol;
      end else begin
        sclk_pad_i = ~mCpol;
        mosi_pad_i = mosiWord[idx];
        waitClk(HALF);
        misoWord[idx] = miso_pad_o;
        sclk_pad_i = mCpol;
        waitClk(HALF);
      end
    end
  endtask

  // One full single-character transfer with its checks.
  task automatic runSingle(input string tag, input int mode, input bit lsb, input int len,
                           input logic [DW-1:0] txw, input logic [DW-1:0] mw);
    logic [DW-1:0] got;
    int rx0, q0;
    setMode(mode, lsb, len);
    writeTx(txw);
    rx0 = rxCount;
    q0  = rxQ.size();
    beginSelect();
    applyStimulus(mw, len, len, got);
    endSelect();
    checkOutput({tag, "_miso"}, got, maskLen(txw, len));
    checkOutput({tag, "_rxcnt"}, DW'(rxCount - rx0), DW'(1));
    if (rxQ.size() > q0) checkOutput({tag, "_rxdata"}, rxQ[q0], maskLen(mw, len));
    else failTimeout({tag, "_rxdata"});
  endtask

  initial begin
    logic [DW-1:0] got, w0, w1, w2, v0, v2;
    logic [DW-1:0] b2bWords[3];
    int rx0, ur0, ab0, oe0, q0;

    rst = 1'b0; ss_pad_i = '1; sclk_pad_i = 1'b0; mosi_pad_i = 1'b0;
    cfg_ss_idx = 3'd0; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_char_len = 5'd8;
    tx_data = '0; tx_valid = 1'b0;
    waitClk(3);

    // Reset values.
    checkOutput("rst_tx_ready", DW'(tx_ready), DW'(1));
    checkOutput("rst_miso_oe", DW'(miso_oe_o), DW'(0));
    checkOutput("rst_miso", DW'(miso_pad_o), DW'(0));
    checkOutput("rst_rx_valid", DW'(rx_valid), DW'(0));
    checkOutput("rst_rx_data", rx_data, DW'(0));
    checkOutput("rst_strobes", DW'({tx_underrun, abort}), DW'(0));
    rst = 1'b1;
    waitClk(5);

    // Mode 0, 8 bits MSB first.
    setMode(0, 0, 8);
    writeTx(32'hA5);
    checkOutput("tx_ready_after_write", DW'(tx_ready), DW'(0));
    rx0 = rxCount; q0 = rxQ.size();
    beginSelect();
    checkOutput("miso_oe_active", DW'(miso_oe_o), DW'(1));
    applyStimulus(32'h3C, 8, 8, got);
    endSelect();
    checkOutput("m0_miso", got, 32'hA5);
    checkOutput("m0_rxcnt", DW'(rxCount - rx0), DW'(1));
    if (rxQ.size() > q0) checkOutput("m0_rxdata", rxQ[q0], 32'h3C);
    else failTimeout("m0_rxdata");
    checkOutput("idle_miso_oe", DW'(miso_oe_o), DW'(0));

    // Modes 1..3, LSB first, full 32-bit characters.
    for (int m = 1; m < 4; m++)
      runSingle($sformatf("mode%0d", m), m, 1'b1, 32, 32'hDEADBEEF, 32'h12345678);

    // Randomised modes, orders and lengths.
    for (int r = 0; r < 5; r++)
      runSingle($sformatf("rand%0d", r), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                int'($urandom_range(1, 32)), DW'($urandom), DW'($urandom));

    // Back-to-back 16-bit characters with refill after every drain.
    setMode(0, 0, 16);
    for (int i = 0; i < 3; i++) b2bWords[i] = DW'($urandom_range(0, 16'hFFFF));
    w0 = b2bWords[0]; w1 = b2bWords[1]; w2 = b2bWords[2];
    writeTx(w0);
    rx0 = rxCount; ur0 = underrunCount; q0 = rxQ.size();
    beginSelect();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          applyStimulus(DW'(16'h1000 + i), 16, 16, got);
          checkOutput($sformatf("b2b_miso%0d", i), got, b2bWords[i]);
        end
      end
      begin
        writeTx(w1);
        writeTx(w2);
        writeTx(DW'($urandom_range(0, 16'hFFFF)));
      end
    join
    endSelect();
    checkOutput("b2b_rxcnt", DW'(rxCount - rx0), DW'(3));
    checkOutput("b2b_underrun", DW'(underrunCount - ur0), DW'(0));
    if (rxQ.size() >= q0 + 3) checkOutput("b2b_rx2", rxQ[q0 + 2], DW'(16'h1002));
    else failTimeout("b2b_rx2");

    // Same again but the second character is not refilled in time.
    v0 = DW'($urandom_range(0, 16'hFFFF));
    v2 = DW'($urandom_range(0, 16'hFFFF));
    writeTx(v0);
    ur0 = underrunCount;
    beginSelect();
    fork
      begin
        applyStimulus(32'h0000_1111, 16, 16, got);
        checkOutput("ur_miso0", got, v0);
        applyStimulus(32'h0000_2222, 16, 16, got);
        checkOutput("ur_miso1", got, DW'(0));
      end
      begin
        int n = 0;
        while (underrunCount == ur0 && n < 1000) begin
          waitClk(1);
          n++;
        end
        if (underrunCount == ur0) failTimeout("ur_wait");
        writeTx(v2);
      end
    join
    endSelect();
    checkOutput("ur_count", DW'(underrunCount - ur0), DW'(1));

    // Select rises after 5 of 8 bits.
    setMode(0, 0, 8);
    writeTx(32'h5A);
    rx0 = rxCount; ab0 = abortCount;
    beginSelect();
    applyStimulus(32'hFF, 8, 5, got);
    endSelect();
    checkOutput("abort_count", DW'(abortCount - ab0), DW'(1));
    checkOutput("abort_rxcnt", DW'(rxCount - rx0), DW'(0));
    runSingle("after_abort", 0, 1'b0, 8, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));

    // Endpoint on index 3, master selects index 2.
    cfg_ss_idx = 3'd3;
    selIdx = 2;
    setMode(0, 0, 8);
    rx0 = rxCount; ur0 = underrunCount; ab0 = abortCount; oe0 = oeCount;
    beginSelect();
    applyStimulus(32'h81, 8, 8, got);
    endSelect();
    checkOutput("other_oe", DW'(oeCount - oe0), DW'(0));
    checkOutput("other_miso", got, DW'(0));
    checkOutput("other_strobes", DW'((rxCount - rx0) + (underrunCount - ur0) + (abortCount - ab0)), DW'(0));

    // Index 3 with cfg_cpol flipped mid-character.
    selIdx = 3;
    writeTx(32'hC3);
    rx0 = rxCount; q0 = rxQ.size();
    beginSelect();
    fork
      applyStimulus(32'h96, 8, 8, got);
      begin
        waitClk(30);
        cfg_cpol = 1'b1;
      end
    join
    endSelect();
    cfg_cpol = 1'b0;
    checkOutput("cpolchg_miso", got, 32'hC3);
    if (rxQ.size() > q0) checkOutput("cpolchg_rx", rxQ[q0], 32'h96);
    else failTimeout("cpolchg_rx");
    cfg_ss_idx = 3'd0;
    selIdx = 0;

    // Reset in the middle of a character.
    setMode(0, 0, 8);
    writeTx(32'hF0);
    beginSelect();
    applyStimulus(32'h0F, 8, 3, got);
    rx0 = rxCount; ab0 = abortCount;
    rst = 1'b0;
    waitClk(2);
    checkOutput("midrst_tx_ready", DW'(tx_ready), DW'(1));
    checkOutput("midrst_oe_miso", DW'({miso_oe_o, miso_pad_o}), DW'(0));
    checkOutput("midrst_rx_data", rx_data, DW'(0));
    ss_pad_i = '1;
    sclk_pad_i = 1'b0;
    waitClk(3);
    rst = 1'b1;
    waitClk(5);
    checkOutput("midrst_nopulse", DW'((rxCount - rx0) + (abortCount - ab0)), DW'(0));
    runSingle("after_rst", 0, 1'b0, 8, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slave_endpoint.md
# spi_slave_endpoint

Parametrised, synthesisable SPI slave endpoint that answers the SPI master core's pad outputs (`ss_pad_o`, `sclk_pad_o`, `mosi_pad_o`) and drives its `miso_pad_i`. It is the next generation of our SPI slave side, which until now existed only as bench-driven pins. It adds a runtime-selectable slave index among `SS_NB` selects, all four CPOL/CPHA modes, MSB/LSB order, a variable character length up to `DW`, back-to-back characters under one select, and TX/RX handshakes. It sits in the system `clk` domain and oversamples the SPI pins.

## Interface
Parameters:
- `SS_NB`, 8, number of slave-select lines seen on the bus
- `DW`, 32, maximum character length and data width
- `SYNC_STAGES`, 2, synchroniser depth for `ss`, `sclk` and `mosi` (minimum 2)

Ports:
- `clk`, in, 1, system clock
- `rst`, in, 1, reset, asynchronous, active-low
- `ss_pad_i`, in, `SS_NB`, slave selects, active-low
- `sclk_pad_i`, in, 1, serial clock
- `mosi_pad_i`, in, 1, master out slave in
- `miso_pad_o`, out, 1, master in slave out
- `miso_oe_o`, out, 1, MISO output enable
- `cfg_ss_idx`, in, `$clog2(SS_NB)`, index of the select line this endpoint answers
- `cfg_cpol`, in, 1, SCLK idle level
- `cfg_cpha`, in, 1, clock phase
- `cfg_lsb`, in, 1, 1 = LSB first
- `cfg_char_len`, in, `$clog2(DW)`, bits per character; 0 means `DW`
- `tx_data`, in, `DW`, next character to transmit
- `tx_valid`, in, 1, `tx_data` is valid
- `tx_ready`, out, 1, TX buffer is empty
- `rx_data`, out, `DW`, received character, right-aligned, upper bits 0
- `rx_valid`, out, 1, one-cycle strobe
- `tx_underrun`, out, 1, one-cycle strobe
- `abort`, out, 1, one-cycle strobe

## Operation
- Synchroniser: `ss_pad_i[cfg_ss_idx]`, `sclk_pad_i` and `mosi_pad_i` each pass through `SYNC_STAGES` flops. Edges are detected on the synchronised SCLK.
  - Leading edge: a transition away from `cfg_cpol`.
  - Trailing edge: a transition back to `cfg_cpol`.
- FSM states: `IDLE`, `LOAD`, `ACTIVE`.
  - `IDLE`: on a falling edge of the synchronised select, latch the `cfg_*` inputs, then go to `LOAD`.
  - `LOAD` (1 cycle): shift register ← TX buffer if full, otherwise all zeros with a `tx_underrun` pulse. Clear the bit counter. Go to `ACTIVE`.
  - `ACTIVE`: on select rise, go to `IDLE`. If the bit counter ≠ 0, pulse `abort` and discard the partial character.
- CPHA=0:
  - Sample MOSI on the leading edge.
  - Shift the next MISO bit out on the trailing edge.
  - The first bit is valid on MISO from `LOAD`.
- CPHA=1:
  - Shift on the leading edge; the first bit is presented on the first leading edge.
  - Sample on the trailing edge.
- MISO bit order:
  - MSB first: `miso_pad_o` = shift register bit `len-1`.
  - LSB first: `miso_pad_o` = shift register bit 0.
- End of character: after `len` samples, capture `rx_data` and pulse `rx_valid`. The next character is reloaded exactly as in `LOAD`, in the same cycle. The FSM stays in `ACTIVE`.
- TX buffer: single entry.
  - `tx_ready` = !full.
  - Write occurs on `tx_valid && tx_ready`.
  - Drained at `LOAD` or at the reload.
- Config inputs are ignored while in `ACTIVE`.
- `miso_oe_o` = 1 only in `LOAD`/`ACTIVE`. `miso_pad_o` = 0 whenever `miso_oe_o` = 0.
- Reset values:
  - FSM `IDLE`.
  - `tx_ready`=1.
  - All other outputs 0.
  - Synchronisers set to the select-inactive level (1) and the SCLK idle level (0).

## Timing
- SCLK: each half-period must be ≥ `SYNC_STAGES`+2 `clk` cycles. Faster SCLK is out of spec and behaviour is undefined.
- `rx_valid`: asserted `SYNC_STAGES`+1 cycles after the pad edge of the final sampling SCLK edge. It has no backpressure; an unread `rx_data` is overwritten.
- `tx_ready`:
  - Falls the cycle after the write.
  - Rises the cycle after the drain.
  - The drain and a write attempt in the same cycle: the write is not accepted, since `tx_ready` was 0.
  - A write arriving while empty, in the same cycle as a reload: the character reloads zeros, `tx_underrun` pulses, and the write lands in the buffer for the next character.
- Select rising and the final sample in the same cycle: the sample completes, `rx_valid` pulses, and there is no `abort`.
- Reset mid-transfer: all state clears immediately, with no `rx_valid` or `abort` pulse.

## Structure
- Package `spi_slv_pkg`:
  - State enum `spi_slv_state_e`.
  - `typedef struct` `spi_slv_cfg_t` holding cpol/cpha/lsb/char_len.
  - Constant `SPI_SLV_MIN_SYNC`=2.
- Sub-module `spi_slv_sync`: parametrised N-stage synchroniser plus edge detector, instantiated once per pin.
- Top level: FSM, bit counter, shift register, TX buffer.

## Test plan
- Mode 0, `DW`=32, char_len=8, MSB first, TX loaded 0xA5, master sends 0x3C:
  - MISO shows 1010_0101.
  - `rx_data`=0x3C, a single `rx_valid` pulse.
- Modes 1, 2 and 3, LSB first, char_len=0 (32 bits), TX 0xDEADBEEF, master sends 0x12345678:
  - Both words match in every mode.
- Back-to-back: 3×16-bit characters under one select, TX refilled after each `tx_ready`:
  - 3 `rx_valid` pulses, no `tx_underrun`.
  - Then repeat with no refill before the 2nd character: `tx_underrun` pulses once and the 2nd MISO character is 0x0000.
- Select rises after 5 of 8 bits:
  - `abort` pulses once, no `rx_valid`.
  - The next select starts clean at bit 0.
- `cfg_ss_idx`=3, master selects index 2:
  - `miso_oe_o` stays 0, no strobes.
  - Change `cfg_cpol` mid-transfer on index 3: the current character is unaffected.
- Assert `rst` low mid-character:
  - All outputs return to reset values, `tx_ready`=1.
  - After release, a full 8-bit transfer passes.
